pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage interrupt-capable pipelined CPU. Every cycle it drives the stall enables of the PC and the four pipeline registers, the bubble-insert (flush) controls for IF/ID and ID/EX, and the PC source select. It resolves load-use hazards, taken branches, ERET and memory wait. It also runs the interrupt entry sequence (drain, EPC capture, vector) and owns the EPC and interrupt-enable (IE) state.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_hazard_detect.sv | 29 ++
 rtl/pipe_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared encodings for the pipeline stall/flush sequencer.
//   - FSM state codes (RUN / DRAIN / VECTOR)
//   - PC source select codes driven on pc_sel
//   - interrupt vector address used by the fetch stage
//   - ctrl_t: bundle of all per-cycle combinational controls
//   - reg_match(): one source-operand dependency test
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_VECTOR = 2'd2;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;  // sequential or branch target
  localparam logic [1:0] PC_SEL_EPC = 2'd1;  // return from exception
  localparam logic [1:0] PC_SEL_VEC = 2'd2;  // interrupt vector

  localparam logic [31:0] VEC_ADDR = 32'h0000_0080;

  typedef struct packed {
    logic       stall_pc;
    logic       stall_ifid;
    logic       stall_idex;
    logic       stall_exmem;
    logic       stall_memwb;
    logic       flush_ifid;
    logic       flush_idex;
    logic [1:0] pc_sel;
    logic       int_ack;
  } ctrl_t;

  // True when an operand that ID really reads names the EX destination.
  function automatic logic reg_match(input logic       used,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect
//   Combinational load-use detector. Flags the case where the instruction
//   in ID reads a register that the load currently in EX will write; the
//   load data is not available for forwarding until MEM.
// Ports
//   ex_wreg, ex_m2reg  EX writes a register / EX is a load
//   ex_rd              EX destination register
//   id_rs, id_rt       ID source registers
//   id_use_rs/rt       ID really reads rs / rt
//   load_use           one-cycle stall is needed
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       load_use
);

  // r0 is hardwired zero, so a "load to r0" never creates a dependency.
  assign load_use = ex_wreg && ex_m2reg && (ex_rd != 5'd0) &&
                    (reg_match(id_use_rs, id_rs, ex_rd) ||
                     reg_match(id_use_rt, id_rt, ex_rd));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Central stall/flush sequencer for the five-stage pipeline. Drives the
//   PC and pipeline-register stall enables, the IF/ID and ID/EX bubble
//   controls and the PC source select. Resolves load-use hazards, taken
//   branches, ERET and data-memory wait, and runs the interrupt entry
//   sequence (drain EX/MEM/WB, capture EPC, vector). Owns epc and ie.
//
//   Handshake: there is no valid/ready pair here; mem_wait acts as a
//   global "not ready" that freezes every register, including this
//   block's own state, for each cycle it is high.
//
// Ports
//   clk, clr           clock, asynchronous active-high reset
//   intr               level interrupt request
//   mem_wait           data memory not ready, freeze everything
//   id_valid           IF/ID holds a real instruction
//   id_pc, if_pc       PCs of ID / IF instruction
//   id_rs, id_rt, id_use_rs, id_use_rt   ID operand info
//   ex_rd, ex_wreg, ex_m2reg             EX destination info
//   id_branch_taken    taken branch/jump in ID
//   id_eret            ERET decoded in ID
//   stall_*            hold the register (1 = hold)
//   flush_ifid/idex    load a bubble at the next edge
//   pc_sel             0 seq/branch, 1 EPC, 2 vector
//   epc, ie            saved return PC, interrupt enable
//   int_ack            one-cycle pulse in the VECTOR cycle
//   busy               state != RUN
//   dbg_state          raw FSM state for observation
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int       DRAIN_CYCLES = 3,
  parameter bit       IE_RESET     = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        intr,
  input  logic        mem_wait,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] if_pc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        id_branch_taken,
  input  logic        id_eret,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        stall_memwb,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  pc_sel,
  output logic [31:0] epc,
  output logic        ie,
  output logic        int_ack,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Counter is loaded with DRAIN_CYCLES-1 so DRAIN lasts DRAIN_CYCLES cycles.
  localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);

  logic [1:0]  state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] epc_nxt;
  logic        ie_nxt;
  logic        load_use;
  logic        accept;
  ctrl_t       ctl;

  hazard_detect u_hazard (
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rd     (ex_rd),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .load_use  (load_use)
  );

  assign accept = (state == ST_RUN) && intr && ie;

  always_comb begin
    ctl       = '0;
    ctl.pc_sel = PC_SEL_SEQ;
    state_nxt = state;
    cnt_nxt   = cnt;
    epc_nxt   = epc;
    ie_nxt    = ie;

    if (mem_wait) begin
      // Whole pipeline frozen; no sequencer state may advance either.
      ctl.stall_pc    = 1'b1;
      ctl.stall_ifid  = 1'b1;
      ctl.stall_idex  = 1'b1;
      ctl.stall_exmem = 1'b1;
      ctl.stall_memwb = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            // Freeze the front end and bubble ID/EX; the ID instruction
            // (or IF if ID is a bubble) re-executes after return, so any
            // branch/ERET it carries is simply not acted on now.
            ctl.stall_pc   = 1'b1;
            ctl.stall_ifid = 1'b1;
            ctl.flush_idex = 1'b1;
            epc_nxt        = id_valid ? id_pc : if_pc;
            cnt_nxt        = CNT_INIT;
            state_nxt      = ST_DRAIN;
          end else if (load_use) begin
            ctl.stall_pc   = 1'b1;
            ctl.stall_ifid = 1'b1;
            ctl.flush_idex = 1'b1;
          end else if (id_eret && id_valid) begin
            ctl.pc_sel     = PC_SEL_EPC;
            ctl.flush_ifid = 1'b1;
            ie_nxt         = 1'b1;
          end else if (id_branch_taken && id_valid) begin
            ctl.flush_ifid = 1'b1;
          end
        end
        ST_DRAIN: begin
          ctl.stall_pc   = 1'b1;
          ctl.stall_ifid = 1'b1;
          ctl.flush_idex = 1'b1;
          if (cnt == 3'd0) begin
            state_nxt = ST_VECTOR;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
        ST_VECTOR: begin
          ctl.pc_sel     = PC_SEL_VEC;
          ctl.flush_ifid = 1'b1;
          ctl.flush_idex = 1'b1;
          ctl.int_ack    = 1'b1;
          ie_nxt         = 1'b0;
          state_nxt      = ST_RUN;
        end
        default: begin
          // Unused encoding: recover to RUN without side effects.
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_RUN;
      cnt   <= 3'd0;
      epc   <= 32'd0;
      ie    <= IE_RESET;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      epc   <= epc_nxt;
      ie    <= ie_nxt;
    end
  end

  assign stall_pc    = ctl.stall_pc;
  assign stall_ifid  = ctl.stall_ifid;
  assign stall_idex  = ctl.stall_idex;
  assign stall_exmem = ctl.stall_exmem;
  assign stall_memwb = ctl.stall_memwb;
  assign flush_ifid  = ctl.flush_ifid;
  assign flush_idex  = ctl.flush_idex;
  assign pc_sel      = ctl.pc_sel;
  assign int_ack     = ctl.int_ack;
  assign busy        = (state != ST_RUN);
  assign dbg_state   = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk, clr;
  logic        intr, mem_wait, id_valid;
  logic [31:0] id_pc, if_pc;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, ex_wreg, ex_m2reg;
  logic        id_branch_taken, id_eret;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic        flush_ifid, flush_idex, int_ack, busy, ie;
  logic [1:0]  pc_sel, dbg_state;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  // {stall_pc,stall_ifid,stall_idex,stall_exmem,stall_memwb,
  //  flush_ifid,flush_idex,pc_sel[1:0],int_ack,busy}
  logic [10:0] obs;
  assign obs = {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                flush_ifid, flush_idex, pc_sel, int_ack, busy};

  localparam logic [10:0] P_IDLE   = 11'b00000_00_00_0_0;
  localparam logic [10:0] P_HOLD   = 11'b11000_01_00_0_0;  // load-use / accept
  localparam logic [10:0] P_DRAIN  = 11'b11000_01_00_0_1;
  localparam logic [10:0] P_VECTOR = 11'b00000_11_10_1_1;
  localparam logic [10:0] P_ERET   = 11'b00000_10_01_0_0;
  localparam logic [10:0] P_BRANCH = 11'b00000_10_00_0_0;
  localparam logic [10:0] P_WAIT_R = 11'b11111_00_00_0_0;  // mem_wait in RUN
  localparam logic [10:0] P_WAIT_B = 11'b11111_00_00_0_1;  // mem_wait while busy

  pipe_ctrl #(.DRAIN_CYCLES(3), .IE_RESET(1'b1)) dut (
    .clk(clk), .clr(clr), .intr(intr), .mem_wait(mem_wait),
    .id_valid(id_valid), .id_pc(id_pc), .if_pc(if_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .id_branch_taken(id_branch_taken), .id_eret(id_eret),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .pc_sel(pc_sel),
    .epc(epc), .ie(ie), .int_ack(int_ack), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic idle_inputs();
    intr = 0; mem_wait = 0; id_valid = 0; id_pc = 0; if_pc = 0;
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rd = 0; ex_wreg = 0; ex_m2reg = 0; id_branch_taken = 0; id_eret = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    idle_inputs();
    #2;
    checks++; if (obs !== P_IDLE) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", obs, P_IDLE); end
    checks++; if (epc !== 32'd0) begin errors++; $display("FAIL reset_epc got=%h exp=0", epc); end
    checks++; if (ie !== 1'b1) begin errors++; $display("FAIL reset_ie got=%b exp=1", ie); end
    next_cycle();
    next_cycle();
    clr = 1'b0;
    #1;
    checks++; if (obs !== P_IDLE || dbg_state !== 2'd0) begin errors++; $display("FAIL post_reset got=%b st=%0d exp=%b st=0", obs, dbg_state, P_IDLE); end
  endtask

  task automatic test_load_use();
    next_cycle();
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    id_valid = 1; id_branch_taken = 1; id_eret = 1;  // both must be ignored
    #1;
    checks++; if (obs !== P_HOLD) begin errors++; $display("FAIL load_use_rs got=%b exp=%b", obs, P_HOLD); end
    next_cycle();
    idle_inputs();   // load has moved to MEM
    #1;
    checks++; if (obs !== P_IDLE || ie !== 1'b1) begin errors++; $display("FAIL load_use_one_cycle got=%b ie=%b exp=%b ie=1", obs, ie, P_IDLE); end
    next_cycle();
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    #1;
    checks++; if (obs !== P_IDLE) begin errors++; $display("FAIL load_use_r0 got=%b exp=%b", obs, P_IDLE); end
    next_cycle();
    ex_rd = 9; id_rs = 3; id_use_rs = 1; id_rt = 9; id_use_rt = 1;
    #1;
    checks++; if (obs !== P_HOLD) begin errors++; $display("FAIL load_use_rt got=%b exp=%b", obs, P_HOLD); end
    next_cycle();
    id_use_rt = 0;  // rt matches but is not read
    #1;
    checks++; if (obs !== P_IDLE) begin errors++; $display("FAIL load_use_unused got=%b exp=%b", obs, P_IDLE); end
    next_cycle();
    idle_inputs();
    id_branch_taken = 1; id_valid = 1;
    #1;
    checks++; if (obs !== P_BRANCH) begin errors++; $display("FAIL branch got=%b exp=%b", obs, P_BRANCH); end
    next_cycle();
    id_valid = 0;
    #1;
    checks++; if (obs !== P_IDLE) begin errors++; $display("FAIL branch_bubble got=%b exp=%b", obs, P_IDLE); end
  endtask

  task automatic test_interrupt();
    next_cycle();
    idle_inputs();
    intr = 1; id_valid = 1; id_pc = 32'h40; if_pc = 32'h44; id_branch_taken = 1;
    #1;
    checks++; if (obs !== P_HOLD) begin errors++; $display("FAIL int_accept got=%b exp=%b", obs, P_HOLD); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      idle_inputs();
      #1;
      checks++; if (obs !== P_DRAIN || dbg_state !== 2'd1) begin errors++; $display("FAIL int_drain%0d got=%b st=%0d exp=%b st=1", c, obs, dbg_state, P_DRAIN); end
    end
    checks++; if (epc !== 32'h40) begin errors++; $display("FAIL int_epc got=%h exp=00000040", epc); end
    next_cycle();
    #1;
    checks++; if (obs !== P_VECTOR || ie !== 1'b1) begin errors++; $display("FAIL int_vector got=%b ie=%b exp=%b ie=1", obs, ie, P_VECTOR); end
    next_cycle();
    #1;
    checks++; if (obs !== P_IDLE || ie !== 1'b0) begin errors++; $display("FAIL int_after got=%b ie=%b exp=%b ie=0", obs, ie, P_IDLE); end
    intr = 1; id_valid = 1; id_pc = 32'h50;
    next_cycle();
    #1;
    checks++; if (obs !== P_IDLE || epc !== 32'h40) begin errors++; $display("FAIL int_masked got=%b epc=%h exp=%b epc=00000040", obs, epc, P_IDLE); end
  endtask

  task automatic test_eret();
    next_cycle();
    idle_inputs();
    intr = 1; id_eret = 1; id_valid = 1; id_pc = 32'h70;
    #1;
    checks++; if (obs !== P_ERET || ie !== 1'b0) begin errors++; $display("FAIL eret got=%b ie=%b exp=%b ie=0", obs, ie, P_ERET); end
    next_cycle();
    id_eret = 0; id_pc = 32'h60;
    #1;
    checks++; if (obs !== P_HOLD || ie !== 1'b1) begin errors++; $display("FAIL eret_reaccept got=%b ie=%b exp=%b ie=1", obs, ie, P_HOLD); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      idle_inputs();
      #1;
      checks++; if (obs !== P_DRAIN) begin errors++; $display("FAIL eret_drain%0d got=%b exp=%b", c, obs, P_DRAIN); end
    end
    checks++; if (epc !== 32'h60) begin errors++; $display("FAIL eret_epc got=%h exp=00000060", epc); end
    next_cycle();
    #1;
    checks++; if (obs !== P_VECTOR) begin errors++; $display("FAIL eret_vector got=%b exp=%b", obs, P_VECTOR); end
    next_cycle();
    #1;
    checks++; if (ie !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL eret_end ie=%b busy=%b exp ie=0 busy=0", ie, busy); end
  endtask

  task automatic test_mem_wait();
    next_cycle();
    idle_inputs();
    id_eret = 1; id_valid = 1;
    #1;
    checks++; if (obs !== P_ERET) begin errors++; $display("FAIL mw_eret got=%b exp=%b", obs, P_ERET); end
    next_cycle();
    idle_inputs();
    mem_wait = 1; intr = 1; id_valid = 1; id_pc = 32'h90;
    #1;
    checks++; if (obs !== P_WAIT_R || ie !== 1'b1) begin errors++; $display("FAIL mw_run got=%b ie=%b exp=%b ie=1", obs, ie, P_WAIT_R); end
    next_cycle();
    mem_wait = 0; id_pc = 32'h100;
    #1;
    checks++; if (obs !== P_HOLD || epc !== 32'h60) begin errors++; $display("FAIL mw_accept got=%b epc=%h exp=%b epc=00000060", obs, epc, P_HOLD); end
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (obs !== P_DRAIN || epc !== 32'h100) begin errors++; $display("FAIL mw_drain1 got=%b epc=%h exp=%b epc=00000100", obs, epc, P_DRAIN); end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      mem_wait = 1;
      #1;
      checks++; if (obs !== P_WAIT_B) begin errors++; $display("FAIL mw_freeze%0d got=%b exp=%b", c, obs, P_WAIT_B); end
    end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      mem_wait = 0;
      #1;
      checks++; if (obs !== P_DRAIN) begin errors++; $display("FAIL mw_drain_tail%0d got=%b exp=%b", c, obs, P_DRAIN); end
    end
    next_cycle();
    #1;
    checks++; if (obs !== P_VECTOR) begin errors++; $display("FAIL mw_vector got=%b exp=%b", obs, P_VECTOR); end
    next_cycle();
    #1;
    checks++; if (obs !== P_IDLE || ie !== 1'b0) begin errors++; $display("FAIL mw_end got=%b ie=%b exp=%b ie=0", obs, ie, P_IDLE); end
  endtask

  task automatic test_priority();
    next_cycle();
    idle_inputs();
    id_eret = 1; id_valid = 1;
    #1;
    checks++; if (obs !== P_ERET) begin errors++; $display("FAIL pri_eret got=%b exp=%b", obs, P_ERET); end
    next_cycle();
    idle_inputs();
    intr = 1; id_branch_taken = 1; id_valid = 0;
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 7; id_rs = 7; id_use_rs = 1;
    if_pc = 32'h200; id_pc = 32'h300;
    #1;
    checks++; if (obs !== P_HOLD) begin errors++; $display("FAIL pri_accept got=%b exp=%b", obs, P_HOLD); end
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (obs !== P_DRAIN || epc !== 32'h200) begin errors++; $display("FAIL pri_if_pc got=%b epc=%h exp=%b epc=00000200", obs, epc, P_DRAIN); end
  endtask

  task automatic test_clr_drain();
    next_cycle();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_pre busy=%b exp=1", busy); end
    #2;
    clr = 1'b1;
    #1;
    checks++; if (obs !== P_IDLE || dbg_state !== 2'd0) begin errors++; $display("FAIL clr_async got=%b st=%0d exp=%b st=0", obs, dbg_state, P_IDLE); end
    checks++; if (epc !== 32'd0 || ie !== 1'b1) begin errors++; $display("FAIL clr_regs epc=%h ie=%b exp epc=0 ie=1", epc, ie); end
    #2;
    clr = 1'b0;
    next_cycle();
    #1;
    checks++; if (obs !== P_IDLE) begin errors++; $display("FAIL clr_after got=%b exp=%b", obs, P_IDLE); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_interrupt();
    test_eret();
    test_mem_wait();
    test_priority();
    test_clr_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
